// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension stage.
// Mode encoding matches the decode field driving in_mode.
package imm_ext_pkg;

    localparam int IMM_MODE_W   = 2;
    localparam int IMM_BR_SHIFT = 2;

    typedef enum logic [IMM_MODE_W-1:0] {
        IMM_ZERO   = 2'd0,
        IMM_SIGN   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: ZERO / SIGN / UPPER / BRANCH.
// Latency 0; no handshake. With IMM_EXT_BRANCH_EN undefined, mode 3 extends as SIGN and flags mode_err.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]       imm,
    input  logic [IMM_MODE_W-1:0] mode,
    output logic [OUT_W-1:0]      ext,
    output logic                  mode_err
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;

    always_comb begin
        sext     = {{PAD_W{imm[IN_W-1]}}, imm};
        ext      = sext;
        mode_err = 1'b0;
        case (imm_mode_e'(mode))
            IMM_ZERO:   ext = {{PAD_W{1'b0}}, imm};
            IMM_SIGN:   ext = sext;
            IMM_UPPER:  ext = {imm, {PAD_W{1'b0}}};
            IMM_BRANCH: begin
`ifdef IMM_EXT_BRANCH_EN
                // bits shifted past the MSB are intentionally dropped
                ext = sext << IMM_BR_SHIFT;
`else
                ext      = sext;
                mode_err = 1'b1;
`endif
            end
            default:    ext = sext;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Pipelined immediate extension into a registered two-entry skid buffer (IMM_EXT_BRANCH_EN enables mode 3).
// Latency 1 cycle from acceptance to out_valid; 1 beat/cycle while out_ready is high.
// Backpressure: in_ready is a flop, low only while the skid entry is occupied; no out_ready->in_ready path.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_imm,
    input  logic [IMM_MODE_W-1:0] in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_imm,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_mode_err
);

    logic [OUT_W-1:0] ext_imm;
    logic             ext_err;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm      (in_imm),
        .mode     (in_mode),
        .ext      (ext_imm),
        .mode_err (ext_err)
    );

    logic             main_vld_q, main_vld_d;
    logic [OUT_W-1:0] main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_err_q, main_err_d;
    logic             skid_vld_q, skid_vld_d;
    logic [OUT_W-1:0] skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;
    logic             in_ready_q, in_ready_d;

    logic in_fire;
    logic out_fire;

    always_comb begin
        in_fire    = in_valid & in_ready_q;
        out_fire   = main_vld_q & out_ready;
        main_vld_d = main_vld_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_err_d = main_err_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_err_d = skid_err_q;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_fire && skid_vld_q) begin
            // in_ready is low whenever skid is full, so no new beat competes here
            main_vld_d = 1'b1;
            main_imm_d = skid_imm_q;
            main_tag_d = skid_tag_q;
            main_err_d = skid_err_q;
            skid_vld_d = 1'b0;
        end else if (out_fire || !main_vld_q) begin
            main_vld_d = in_fire;
            if (in_fire) begin
                main_imm_d = ext_imm;
                main_tag_d = in_tag;
                main_err_d = ext_err;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_imm_d = ext_imm;
            skid_tag_d = in_tag;
            skid_err_d = ext_err;
        end

        in_ready_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld_q <= 1'b0;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_err_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_vld_q <= main_vld_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_err_q <= main_err_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_err_q <= skid_err_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_vld_q;
    assign out_imm      = main_imm_q;
    assign out_tag      = main_tag_q;
    assign out_mode_err = main_err_q;

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Parametrised, pipelined immediate-extension stage for the flow CPU decode path. It accepts a narrow immediate field plus an extension mode and a destination tag over a valid/ready handshake. It produces the full-width operand in one of four modes: zero, sign, upper-placement, or branch-offset. The result is held in a registered two-entry skid buffer, so decode back-pressure never forms a combinational path through the block. It sits between instruction field decode and the ID/EX register, and supersedes the fixed 16-to-32 upper-placement extender.

## Interface
- `IN_W`, 16, immediate input width; legal range 1..`OUT_W`-2.
- `OUT_W`, 32, extended operand width.
- `TAG_W`, 5, passthrough tag width (destination register index).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush.
- `in_valid` input 1: upstream beat valid.
- `in_ready` output 1: block can accept a beat; registered.
- `in_imm` input `IN_W`: raw immediate.
- `in_mode` input 2: 0 ZERO, 1 SIGN, 2 UPPER, 3 BRANCH.
- `in_tag` input `TAG_W`: carried unchanged.
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: downstream accepts.
- `out_imm` output `OUT_W`: extended operand.
- `out_tag` output `TAG_W`: tag of the current output beat.
- `out_mode_err` output 1: beat used an unsupported mode.

## Operation
- Extension arithmetic, with `IN_W`=16 and `OUT_W`=32:
  - ZERO: upper `OUT_W-IN_W` bits are 0.
  - SIGN: upper bits replicate `in_imm[IN_W-1]`.
  - UPPER: `in_imm` is placed at `[OUT_W-1:OUT_W-IN_W]`; low bits are 0.
  - BRANCH: sign-extend, then shift left 2; bits shifted out are discarded.
- Handshakes:
  - A transfer occurs on a rising edge where valid and ready are both high.
  - `out_valid` must not drop until the beat is accepted.
  - `out_imm` and `out_tag` are stable while stalled.
- Storage is a main register (drives the outputs) plus a skid register.
  - Accept with main empty, or main draining this cycle: write main.
  - Accept with main full and `out_ready`=0: write skid. `in_ready` deasserts on the next cycle.
  - `out_ready`=1 with skid full: skid moves to main and `in_ready` reasserts.
  - A skid write and a skid drain never occur in the same cycle, because `in_ready`=0 whenever skid is full.
- Ordering is strict FIFO.
- Flush:
  - Both valids clear at the next edge.
  - A beat offered in the flush cycle is dropped.
  - `in_ready`=1 after the flush edge.
- Reset, including mid-transfer: contents are discarded and no beat is emitted.

## Timing
- Latency: 1 cycle from input acceptance to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Combinational paths: none from `out_ready` to `in_ready`, and none from the inputs to any output.
- Reset values: `out_valid`=0, `out_imm`=0, `out_tag`=0, `out_mode_err`=0, `in_ready`=1.
- Simultaneous events:
  - `flush` beats accept and drain in the same cycle.
  - Async `rst_n` overrides everything.

## Configuration
- `IMM_EXT_BRANCH_EN` defined:
  - Mode 3 performs BRANCH.
  - `out_mode_err` is always 0.
- `IMM_EXT_BRANCH_EN` undefined:
  - The shifter is compiled out.
  - A mode-3 beat is extended as SIGN.
  - That beat carries `out_mode_err`=1 for its lifetime in the buffer.

## Structure
- Package `imm_ext_pkg`:
  - mode enum `imm_mode_e` (ZERO, SIGN, UPPER, BRANCH)
  - mode width constant `IMM_MODE_W`=2
  - branch shift constant `IMM_BR_SHIFT`=2
- Sub-module `imm_ext_core`: purely combinational extension logic, parametrised by `IN_W`/`OUT_W`, instantiated once on the input side.
- The top module holds the skid buffer, handshake and flush logic.

## Test plan
- Modes, `out_ready`=1, one beat per cycle, all with `IN_W`=16, `OUT_W`=32:
  - ZERO 0x8001 -> 0x00008001
  - SIGN 0x8001 -> 0xFFFF8001
  - UPPER 0x1234 -> 0x12340000
  - BRANCH 0xFFFF -> 0xFFFFFFFC
  - Each result appears 1 cycle after acceptance; tags are echoed.
- Back-pressure: beats A, B, C (tags 1, 2, 3) on consecutive cycles with `out_ready`=0.
  - A is held; B enters skid; `in_ready` goes low and C is not accepted.
  - Raise `out_ready`: outputs A, B, C in order with no loss or duplication.
- Flush with both entries full and a beat offered: next cycle `out_valid`=0 and `in_ready`=1; the offered beat never appears.
- Reset mid-stall: assert `rst_n`=0 asynchronously between edges.
  - Outputs go to reset values immediately.
  - After release, a new beat ZERO 0x00FF -> 0x000000FF with no stale data.
- Configuration: mode 3 with 0x0004.
  - With `IMM_EXT_BRANCH_EN`: 0x00000010, err 0.
  - Without it: 0x00000004, err 1.
- Streaming: 1000 random beats with random `out_ready` (50%); a scoreboard matches the reference model and confirms `out_imm` is stable while stalled.
